// File: rtl/instruction_memory_loader.sv
// Byte-serial LEGv8 program loader: packs MSB-first bytes into 32-bit words and writes them to imem.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_memory_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  imem_write_en,
  output logic [ADDR_WIDTH-1:0] imem_write_addr,
  output logic [31:0]           imem_write_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;   // words written; low bits double as the write address
  logic [1:0]            idx_q, idx_d;
  logic [23:0]           shift_q, shift_d;
  logic                  byte_ready_d, we_d, cpu_reset_d, busy_d, done_d, err_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [31:0]           wdata_d;
  logic                  xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign xfer = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      words_q         <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      byte_ready      <= 1'b0;
      imem_write_en   <= 1'b0;
      imem_write_addr <= '0;
      imem_write_data <= '0;
      cpu_reset       <= 1'b1;
      busy            <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      words_q         <= words_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      byte_ready      <= byte_ready_d;
      imem_write_en   <= we_d;
      imem_write_addr <= waddr_d;
      imem_write_data <= wdata_d;
      cpu_reset       <= cpu_reset_d;
      busy            <= busy_d;
      load_done       <= done_d;
      load_error      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q          <= csum_d;
`endif
    end
  end

  // Next-state logic produces the next value of every output so all outputs leave a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    words_d      = words_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_ready_d = byte_ready;
    we_d         = 1'b0;
    waddr_d      = imem_write_addr;
    wdata_d      = imem_write_data;
    cpu_reset_d  = cpu_reset;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        byte_ready_d = 1'b0;
        busy_d       = 1'b0;
        if (load_start) begin
          if (word_count == '0 || word_count > MAX_WORDS) begin
            err_d = 1'b1;
          end else begin
            cnt_d        = word_count;
            words_d      = '0;
            idx_d        = '0;
            shift_d      = '0;
            cpu_reset_d  = 1'b1;
            busy_d       = 1'b1;
            byte_ready_d = 1'b1;
            state_d      = S_COLLECT;
`ifdef LOADER_CHECKSUM_EN
            csum_d       = '0;
`endif
          end
        end
      end
      S_COLLECT: begin
        if (xfer) begin
          shift_d = {shift_q[15:0], byte_data};
          idx_d   = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ byte_data;
`endif
          if (idx_q == 2'd3) begin
            state_d      = S_WRITE;
            byte_ready_d = 1'b0;
            we_d         = 1'b1;
            waddr_d      = words_q[ADDR_WIDTH-1:0];
            wdata_d      = {shift_q, byte_data};
          end
        end
      end
      S_WRITE: begin
        words_d = words_q + 1'b1;
        if (words_d == cnt_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d      = S_CHECK;
          byte_ready_d = 1'b1;
`else
          state_d      = S_DONE;
          done_d       = 1'b1;
          cpu_reset_d  = 1'b0;
          busy_d       = 1'b0;
`endif
        end else begin
          state_d      = S_COLLECT;
          byte_ready_d = 1'b1;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer) begin
          byte_ready_d = 1'b0;
          busy_d       = 1'b0;
          if (byte_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: expected writes queued at stimulus, checked at imem_write_en.
module tb_instruction_memory_loader;
  localparam int AW = 6;

  logic          clk = 0, reset = 1, load_start = 0, byte_valid = 0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_ready, imem_write_en, cpu_reset, busy, load_done, load_error;
  logic [AW-1:0] imem_write_addr;
  logic [31:0]   imem_write_data;

  instruction_memory_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_write_en(imem_write_en), .imem_write_addr(imem_write_addr),
    .imem_write_data(imem_write_data), .cpu_reset(cpu_reset), .busy(busy),
    .load_done(load_done), .load_error(load_error));

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t         sb[$];
  logic [31:0] wq[$];
  int n_chk = 0, n_bad = 0, cyc = 0, last_we = 0, n_wr = 0, n_done = 0, n_err = 0;
  logic prev_we = 0, prev_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Write/done/error monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (imem_write_en) begin
      chk("we_one_cycle", prev_we, 0);
      chk("rdy_low_in_write", byte_ready, 0);
      chk("sb_has_exp", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_addr", imem_write_addr, e.addr);
        chk("wr_data", imem_write_data, e.data);
      end
      n_wr++;
      last_we = cyc;
    end
    if (load_done) begin
      n_done++;
`ifndef LOADER_CHECKSUM_EN
      chk("done_latency", cyc - last_we, 1);
`endif
      chk("done_cpu_reset", cpu_reset, 0);
      chk("done_busy", busy, 0);
    end
    if (load_error) begin
      n_err++;
      chk("err_one_cycle", prev_err, 0);
    end
    prev_we  = imem_write_en;
    prev_err = load_error;
  end

  task automatic chk_reset_vals();
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_we", imem_write_en, 0);
    chk("rst_addr", imem_write_addr, 0);
    chk("rst_data", imem_write_data, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
  endtask

  task automatic start_load(input logic [AW:0] cnt);
    @(posedge clk); #1;
    load_start = 1; word_count = cnt;
    @(posedge clk); #1;
    load_start = 0;
  endtask

  // Offer one byte until accepted (byte_ready is registered, so the negedge value predicts the edge).
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got = 0;
    int t = 0;
    byte_valid = 1; byte_data = b;
    while (!got && t < 200) begin
      @(negedge clk);
      if (byte_ready) got = 1;
      @(posedge clk); #1;
      t++;
    end
    chk("byte_accepted", got, 1);
    byte_valid = 0;
    if (gap) begin @(posedge clk); #1; end
  endtask

  // Loads wq; optional ignored load_start mid-word and optional bad checksum.
  task automatic do_load(input bit gap, input bit inj, input bit bad);
    logic [7:0] x = 0;
    int d0 = n_done, e0 = n_err, t = 0;
    for (int i = 0; i < wq.size(); i++) sb.push_back('{AW'(i), wq[i]});
    start_load((AW+1)'(wq.size()));
    chk("busy_on", busy, 1);
    chk("cpu_reset_on", cpu_reset, 1);
    for (int i = 0; i < wq.size(); i++)
      for (int k = 3; k >= 0; k--) begin
        send_byte(wq[i][8*k +: 8], gap);
        x ^= wq[i][8*k +: 8];
        if (inj && i == 0 && k == 2) start_load(1);
      end
`ifdef LOADER_CHECKSUM_EN
    send_byte(x ^ {7'b0, bad}, gap);
`endif
    while (n_done == d0 && n_err == e0 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    chk("load_done_cnt", n_done - d0, bad ? 0 : 1);
    chk("load_err_cnt", n_err - e0, bad ? 1 : 0);
    chk("sb_drained", sb.size(), 0);
    chk("cpu_reset_end", cpu_reset, bad);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    int e0, w0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1 reset = 0;

    // Two-word load, byte_valid held high
    wq = '{32'h8B1F03E9, 32'h91000421};
    do_load(0, 0, 0);
    // Same load with gaps and an ignored load_start mid-word
    do_load(1, 1, 0);

    // Rejects: zero and oversize counts
    e0 = n_err; w0 = n_wr;
    start_load(0);
    repeat (2) @(negedge clk);
    chk("rej0_err", n_err - e0, 1);
    start_load(65);
    repeat (2) @(negedge clk);
    chk("rej65_err", n_err - e0, 2);
    chk("rej_no_write", n_wr - w0, 0);
    chk("rej_cpu_reset_kept", cpu_reset, 0);
    chk("rej_busy", busy, 0);

    // Full-capacity load: last address 2^AW-1
    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back($urandom);
    do_load(0, 0, 0);

    // Abort mid-word with an asynchronous mid-cycle reset
    w0 = n_wr;
    start_load(1);
    send_byte(8'hD6, 0);
    send_byte(8'h5F, 0);
    #3 reset = 1;
    #1 chk_reset_vals();
    @(posedge clk); #1 reset = 0;
    repeat (8) @(negedge clk);
    chk("abort_no_write", n_wr - w0, 0);
    wq = '{32'hD65F03C0};
    do_load(0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
    wq = '{32'h01020304};
    do_load(0, 0, 0);
    do_load(0, 0, 1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_bad);
    $finish;
  end
endmodule
